// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter
//   Serial transmit stage behind the access controller. A word is captured into
//   a holding register on PARALLEL_LOAD. Tx_DATA sends a frame on TX_OUT:
//   a start bit (0), then DATA_W data bits, then a stop bit (1). Each bit lasts
//   CLK_DIV clocks. Every output comes straight from a flop.
//
//   Optional feature: when the macro TX_PARITY_EN is defined, an even-parity bit
//   (XOR of the data bits) is sent between the data bits and the stop bit.
//
// Parameters
//   DATA_W    : data word width (>= 1)
//   CLK_DIV   : clocks per serial bit (>= 1)
//   MSB_FIRST : 0 sends LSB first, 1 sends MSB first
// Ports
//   CLK           : clock, all state changes on posedge
//   RESET         : synchronous reset, active low
//   DATA_IN       : word to transmit, sampled while PARALLEL_LOAD=1 in idle
//   PARALLEL_LOAD : capture DATA_IN into the holding register (idle only)
//   Tx_DATA       : start a frame (idle only); load+start sends the new DATA_IN
//   TX_OUT        : serial line, idles high
//   Tx_DONE       : 1 = idle / last frame complete, 0 = frame in progress
//   BIT_CNT       : debug, index of the bit on the line (0 = start bit)
module serial_tx_shifter #(
  parameter  int DATA_W    = 8,
  parameter  int CLK_DIV   = 4,
  parameter  int MSB_FIRST = 0,
  localparam int BC_W      = $clog2(DATA_W + 3)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              PARALLEL_LOAD,
  input  logic              Tx_DATA,
  output logic              TX_OUT,
  output logic              Tx_DONE,
  output logic [BC_W-1:0]   BIT_CNT
);

  // A 1-bit counter is kept even for CLK_DIV=1; it then sits at terminal count.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [BC_W-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
`ifdef TX_PARITY_EN
  logic                par_q, par_d;
`endif

  logic                tc;
  logic                next_bit;
  logic [DATA_W-1:0]   next_shift;
  logic [DATA_W-1:0]   start_word;

  assign TX_OUT  = tx_q;
  assign Tx_DONE = done_q;
  assign BIT_CNT = bit_q;

  always_comb begin
    tc         = (baud_q == CNT_W'(CLK_DIV - 1));
    next_bit   = (MSB_FIRST != 0) ? shift_q[DATA_W-1] : shift_q[0];
    next_shift = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
    start_word = PARALLEL_LOAD ? DATA_IN : hold_q;

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    done_d  = done_q;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q == S_IDLE) begin
      tx_d   = 1'b1;
      done_d = 1'b1;
      bit_d  = '0;
      baud_d = '0;
      if (PARALLEL_LOAD) hold_d = DATA_IN;
      if (Tx_DATA) begin
        // Start bit goes on the line at this same edge.
        shift_d = start_word;
`ifdef TX_PARITY_EN
        par_d   = ^start_word;
`endif
        tx_d    = 1'b0;
        done_d  = 1'b0;
        state_d = S_START;
      end
    end else begin
      baud_d = tc ? '0 : baud_q + 1'b1;
      if (tc) begin
        bit_d = bit_q + 1'b1;
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            tx_d    = next_bit;
            shift_d = next_shift;
          end
          S_DATA: begin
            if (bit_q == BC_W'(DATA_W)) begin
`ifdef TX_PARITY_EN
              state_d = S_PARITY;
              tx_d    = par_q;
`else
              state_d = S_STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              tx_d    = next_bit;
              shift_d = next_shift;
            end
          end
          S_PARITY: begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
          S_STOP: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            bit_d   = '0;
          end
          default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            bit_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b1;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Scoreboard bench for serial_tx_shifter. Unit 0 is DATA_W=8, CLK_DIV=4, LSB first;
// unit 1 is DATA_W=8, CLK_DIV=1, MSB first. Stimulus tasks run a frame-level
// model (busy countdown + holding word) and queue expected frames; monitors
// capture each Tx_DONE-low window and compare it cycle by cycle.
module tb_serial_tx_shifter;

`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB  = 8 + 2 + PAR;
  localparam int CD0 = 4;
  localparam int CD1 = 1;

  logic       clk = 1'b0;
  logic       rst0, ld0, txd0, tx0, done0;
  logic [7:0] din0;
  logic [3:0] bc0;
  logic       rst1, ld1, txd1, tx1, done1;
  logic [7:0] din1;
  logic [3:0] bc1;

  always #5 clk = ~clk;

  serial_tx_shifter #(.DATA_W(8), .CLK_DIV(CD0), .MSB_FIRST(0)) u_dut (
    .CLK(clk), .RESET(rst0), .DATA_IN(din0), .PARALLEL_LOAD(ld0), .Tx_DATA(txd0),
    .TX_OUT(tx0), .Tx_DONE(done0), .BIT_CNT(bc0));

  serial_tx_shifter #(.DATA_W(8), .CLK_DIV(CD1), .MSB_FIRST(1)) u_dut7 (
    .CLK(clk), .RESET(rst1), .DATA_IN(din1), .PARALLEL_LOAD(ld1), .Tx_DATA(txd1),
    .TX_OUT(tx1), .Tx_DONE(done1), .BIT_CNT(bc1));

  int errors = 0;
  int checks = 0;

  logic [15:0] q_bits0[$], q_bits1[$];
  int          q_len0[$],  q_len1[$];
  int          rem[2];
  logic [7:0]  hold[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as seen on the line, bit 0 first: start, data, [parity], stop.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit msb);
    logic [15:0] fb;
    fb    = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = msb ? d[7-i] : d[i];
    if (PAR != 0) begin
      fb[9]  = ^d;
      fb[10] = 1'b1;
    end else begin
      fb[9] = 1'b1;
    end
    return fb;
  endfunction

  // Drive one cycle of inputs for unit u and advance the model across the edge.
  task automatic step(input int u, input bit rst, input logic [7:0] din,
                      input bit ld, input bit txd);
    int         f;
    logic [7:0] d;
    @(negedge clk);
    if (u == 0) begin rst0 = rst; din0 = din; ld0 = ld; txd0 = txd; end
    else        begin rst1 = rst; din1 = din; ld1 = ld; txd1 = txd; end
    f = NB * ((u == 0) ? CD0 : CD1);
    if (!rst) begin
      // Aborted frame: line stays low-done until the reset edge.
      if (rem[u] > 0) begin
        if (u == 0) q_len0[q_len0.size()-1] = f - rem[u] + 1;
        else        q_len1[q_len1.size()-1] = f - rem[u] + 1;
      end
      rem[u]  = 0;
      hold[u] = 8'h00;
    end else if (rem[u] == 0) begin
      if (txd) begin
        d = ld ? din : hold[u];
        if (u == 0) begin q_bits0.push_back(frame_bits(d, 1'b0)); q_len0.push_back(f); end
        else        begin q_bits1.push_back(frame_bits(d, 1'b1)); q_len1.push_back(f); end
        rem[u] = f;
      end
      if (ld) hold[u] = din;
    end else begin
      rem[u]--;
    end
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) step(u, 1'b1, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic mon(input int u);
    int          low;
    int          el;
    int          cd;
    logic [63:0] aw, ew;
    logic [15:0] fb;
    logic        d, t;
    logic [3:0]  b;
    low = 0;
    aw  = '0;
    cd  = (u == 0) ? CD0 : CD1;
    forever begin
      @(negedge clk);
      d = (u == 0) ? done0 : done1;
      t = (u == 0) ? tx0   : tx1;
      b = (u == 0) ? bc0   : bc1;
      if (!d) begin
        if (low == 0) begin
          aw = '0;
          chk($sformatf("u%0d_frame_expected", u),
              64'(((u == 0) ? q_len0.size() : q_len1.size()) > 0), 64'd1);
        end
        if (low < 64) aw[low] = t;
        low++;
      end else begin
        if (low > 0) begin
          if (((u == 0) ? q_len0.size() : q_len1.size()) > 0) begin
            if (u == 0) begin fb = q_bits0.pop_front(); el = q_len0.pop_front(); end
            else        begin fb = q_bits1.pop_front(); el = q_len1.pop_front(); end
            ew = '0;
            for (int i = 0; i < el && i < 64; i++) ew[i] = fb[i/cd];
            chk($sformatf("u%0d_done_low_len", u), 64'(low), 64'(el));
            chk($sformatf("u%0d_wave", u), aw, ew);
          end
          low = 0;
        end
        chk($sformatf("u%0d_idle_tx", u), 64'(t), 64'd1);
        chk($sformatf("u%0d_idle_bitcnt", u), 64'(b), 64'd0);
      end
    end
  endtask

  task automatic run0();
    step(0, 1'b1, 8'h00, 1'b0, 1'b0);          // release reset
    idle(0, 20);                               // idle stability after reset
    step(0, 1'b1, 8'hA5, 1'b1, 1'b1);          // load + start together
    idle(0, 45);
    step(0, 1'b1, 8'hA5, 1'b1, 1'b1);          // frame with 0xA5
    idle(0, 10);
    step(0, 1'b1, 8'hFF, 1'b1, 1'b1);          // ignored while busy
    idle(0, 35);
    step(0, 1'b1, 8'h3C, 1'b0, 1'b1);          // resend holding reg (0xA5)
    idle(0, 45);
    for (int i = 0; i < 3*(NB*CD0+1) + 2; i++) // Tx_DATA held: back-to-back
      step(0, 1'b1, 8'h00, 1'b0, 1'b1);
    idle(0, 45);
    step(0, 1'b1, 8'h5A, 1'b1, 1'b1);          // reset during data bit 3
    idle(0, 17);
    step(0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(0, 20);
    step(0, 1'b1, 8'h77, 1'b0, 1'b1);          // holding reg cleared by reset
    idle(0, 45);
    step(0, 1'b1, 8'h07, 1'b1, 1'b1);          // parity sample word
    idle(0, 45);
    for (int i = 0; i < 600; i++)
      step(0, ($urandom_range(0, 299) != 0), 8'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    idle(0, 60);
  endtask

  task automatic run1();
    step(1, 1'b1, 8'h00, 1'b0, 1'b0);
    idle(1, 3);
    step(1, 1'b1, 8'h80, 1'b1, 1'b1);          // MSB first, one clock per bit
    idle(1, 15);
    for (int i = 0; i < 40; i++)               // back-to-back at CLK_DIV=1
      step(1, 1'b1, 8'($urandom), ($urandom_range(0, 1) == 0), 1'b1);
    idle(1, 20);
  endtask

  initial begin
    rst0 = 1'b0; ld0 = 1'b0; txd0 = 1'b0; din0 = 8'h00;
    rst1 = 1'b0; ld1 = 1'b0; txd1 = 1'b0; din1 = 8'h00;
    rem  = '{0, 0};
    hold = '{8'h00, 8'h00};
    @(negedge clk);
    @(negedge clk);
    chk("reset_tx", 64'(tx0), 64'd1);
    chk("reset_done", 64'(done0), 64'd1);
    chk("reset_bitcnt", 64'(bc0), 64'd0);
    fork
      mon(0);
      mon(1);
    join_none
    fork
      run0();
      run1();
    join
    chk("u0_pending_frames", 64'(q_len0.size()), 64'd0);
    chk("u1_pending_frames", 64'(q_len1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
